// File: rtl/tw_rom_seq_ctrl.sv
// Twiddle ROM bank sequencer: loads the stage-0 words, then walks every stage issuing CEN/stage/state.
// Optional macro TW_SEQ_STALL_EN: when defined, `stall` suppresses read cycles in the RUN states.
module tw_rom_seq_ctrl #(
    parameter int SC_WIDTH   = 3,
    parameter int S_WIDTH    = 4,
    parameter int P_WIDTH    = 64,
    parameter int STAGE_NUM  = 3,
    parameter int LOAD_WORDS = 4,
    parameter int BLOCK_LEN  = 16,
    parameter int BLOCKS     = 64
) (
    input  logic                CLK,
    input  logic                rst,
    input  logic                start,
    input  logic                load_valid,
    input  logic [P_WIDTH-1:0]  load_data,
    input  logic                stall,
    output logic                load_ready,
    output logic                ROM0_w,
    output logic [P_WIDTH-1:0]  horizontal_data_out,
    output logic                CEN,
    output logic [SC_WIDTH-1:0] stage_counter,
    output logic [S_WIDTH-1:0]  state,
    output logic                tw_valid,
    output logic                load_err,
    output logic                busy,
    output logic                done
);

    localparam int RD_W = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
    localparam int BK_W = (BLOCKS > 1) ? $clog2(BLOCKS) : 1;
    localparam int LD_W = $clog2(LOAD_WORDS + 1);

    localparam logic [S_WIDTH-1:0] ST_IDLE     = S_WIDTH'(0);
    localparam logic [S_WIDTH-1:0] ST_LOAD     = S_WIDTH'(2);
    localparam logic [S_WIDTH-1:0] ST_RUN_EVEN = S_WIDTH'(4);
    localparam logic [S_WIDTH-1:0] ST_GAP      = S_WIDTH'(5);
    localparam logic [S_WIDTH-1:0] ST_RUN_ODD  = S_WIDTH'(6);
    localparam logic [S_WIDTH-1:0] ST_DONE     = S_WIDTH'(8);

    logic [S_WIDTH-1:0] st;
    logic [RD_W-1:0]    rd_cnt;
    logic [BK_W-1:0]    blk_cnt;
    logic [LD_W-1:0]    ld_cnt;

    logic stall_eff;
    logic xfer;
    logic in_run;
    logic rd_fire;
    logic blk_wrap;
    logic last_rd;
    logic last_stage;
    logic ld_last;

`ifdef TW_SEQ_STALL_EN
    assign stall_eff = stall;
`else
    logic unused_stall;
    assign unused_stall = stall;
    assign stall_eff    = 1'b0;
`endif

    assign state      = st;
    assign load_ready = (st == ST_LOAD);
    assign busy       = (st != ST_IDLE);

    assign xfer       = load_valid && load_ready;
    assign ld_last    = (ld_cnt == LD_W'(LOAD_WORDS - 1));
    assign in_run     = (st == ST_RUN_EVEN) || (st == ST_RUN_ODD);
    // A read is issued in the current cycle whenever the registered CEN is low in a RUN state.
    assign rd_fire    = in_run && !CEN;
    assign blk_wrap   = (rd_cnt == RD_W'(BLOCK_LEN - 1));
    assign last_rd    = blk_wrap && (blk_cnt == BK_W'(BLOCKS - 1));
    assign last_stage = (stage_counter == SC_WIDTH'(STAGE_NUM - 1));

    always_ff @(posedge CLK) begin
        if (rst) begin
            st                  <= ST_IDLE;
            rd_cnt              <= '0;
            blk_cnt             <= '0;
            ld_cnt              <= '0;
            stage_counter       <= '0;
            CEN                 <= 1'b1;
            ROM0_w              <= 1'b0;
            horizontal_data_out <= '0;
            tw_valid            <= 1'b0;
            load_err            <= 1'b0;
            done                <= 1'b0;
        end else begin
            ROM0_w   <= xfer;
            if (xfer) begin
                horizontal_data_out <= load_data;
            end
            tw_valid <= rd_fire;
            load_err <= 1'b0;
            done     <= 1'b0;

            case (st)
                ST_IDLE: begin
                    CEN           <= 1'b1;
                    stage_counter <= '0;
                    rd_cnt        <= '0;
                    blk_cnt       <= '0;
                    ld_cnt        <= '0;
                    if (start) begin
                        st <= ST_LOAD;
                    end
                end

                ST_LOAD: begin
                    CEN <= 1'b1;
                    if (xfer) begin
                        if (ld_last) begin
                            // The final ROM write and the first read share the next cycle.
                            ld_cnt <= '0;
                            st     <= ST_RUN_EVEN;
                            CEN    <= 1'b0;
                        end else begin
                            ld_cnt <= ld_cnt + LD_W'(1);
                        end
                    end else if (ld_cnt != '0) begin
                        ld_cnt   <= '0;
                        load_err <= 1'b1;
                    end
                end

                ST_RUN_EVEN, ST_RUN_ODD: begin
                    if (rd_fire) begin
                        if (last_rd) begin
                            CEN <= 1'b1;
                            st  <= last_stage ? ST_DONE : ST_GAP;
                        end else begin
                            CEN <= stall_eff;
                            if (blk_wrap) begin
                                rd_cnt  <= '0;
                                blk_cnt <= blk_cnt + BK_W'(1);
                                st      <= (st == ST_RUN_EVEN) ? ST_RUN_ODD : ST_RUN_EVEN;
                            end else begin
                                rd_cnt <= rd_cnt + RD_W'(1);
                            end
                        end
                    end else begin
                        CEN <= stall_eff;
                    end
                end

                ST_GAP: begin
                    stage_counter <= stage_counter + SC_WIDTH'(1);
                    rd_cnt        <= '0;
                    blk_cnt       <= '0;
                    CEN           <= 1'b0;
                    st            <= ST_RUN_EVEN;
                end

                ST_DONE: begin
                    done          <= 1'b1;
                    CEN           <= 1'b1;
                    stage_counter <= '0;
                    st            <= ST_IDLE;
                end

                default: begin
                    CEN <= 1'b1;
                    st  <= ST_IDLE;
                end
            endcase

            // done is high during the DONE cycle itself, so it is raised on entry.
            if (in_run && rd_fire && last_rd && last_stage) begin
                done <= 1'b1;
            end else if (st == ST_DONE) begin
                done <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tw_rom_seq_ctrl.sv
// Self-checking bench for tw_rom_seq_ctrl: load vector table plus model-checked randomized runs.
module tb_tw_rom_seq_ctrl;

    localparam int SC_WIDTH   = 3;
    localparam int S_WIDTH    = 4;
    localparam int P_WIDTH    = 64;
    localparam int STAGE_NUM  = 3;
    localparam int LOAD_WORDS = 4;
    localparam int BLOCK_LEN  = 16;
    localparam int BLOCKS     = 64;
    localparam int RPS        = BLOCK_LEN * BLOCKS;
    localparam int TOTAL      = STAGE_NUM * RPS;
    localparam int CYC_LIMIT  = 20000;

`ifdef TW_SEQ_STALL_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    localparam int K_READ  = 0;
    localparam int K_STALL = 1;
    localparam int K_GAP   = 2;
    localparam int K_DONE  = 3;
    localparam int K_IDLE  = 4;

    logic                CLK;
    logic                rst;
    logic                start;
    logic                load_valid;
    logic [P_WIDTH-1:0]  load_data;
    logic                stall;
    logic                load_ready;
    logic                ROM0_w;
    logic [P_WIDTH-1:0]  horizontal_data_out;
    logic                CEN;
    logic [SC_WIDTH-1:0] stage_counter;
    logic [S_WIDTH-1:0]  state;
    logic                tw_valid;
    logic                load_err;
    logic                busy;
    logic                done;

    tw_rom_seq_ctrl #(
        .SC_WIDTH(SC_WIDTH), .S_WIDTH(S_WIDTH), .P_WIDTH(P_WIDTH), .STAGE_NUM(STAGE_NUM),
        .LOAD_WORDS(LOAD_WORDS), .BLOCK_LEN(BLOCK_LEN), .BLOCKS(BLOCKS)
    ) dut (
        .CLK(CLK), .rst(rst), .start(start), .load_valid(load_valid), .load_data(load_data),
        .stall(stall), .load_ready(load_ready), .ROM0_w(ROM0_w),
        .horizontal_data_out(horizontal_data_out), .CEN(CEN), .stage_counter(stage_counter),
        .state(state), .tw_valid(tw_valid), .load_err(load_err), .busy(busy), .done(done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_CEN"}, CEN, 1'b1);
        chk({tag, "_ROM0_w"}, ROM0_w, 1'b0);
        chk({tag, "_hdo"}, horizontal_data_out, 64'd0);
        chk({tag, "_stage"}, stage_counter, 0);
        chk({tag, "_state"}, state, 0);
        chk({tag, "_tw_valid"}, tw_valid, 1'b0);
        chk({tag, "_load_ready"}, load_ready, 1'b0);
        chk({tag, "_load_err"}, load_err, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_state", state, 2);
        chk("start_load_ready", load_ready, 1'b1);
        chk("start_busy", busy, 1'b1);
    endtask

    task automatic load4(input logic [63:0] base);
        for (int i = 0; i < LOAD_WORDS; i++) begin
            load_valid = 1'b1;
            load_data  = base + 64'(i);
            tick();
            chk("load_ROM0_w", ROM0_w, 1'b1);
            chk("load_hdo", horizontal_data_out, base + 64'(i));
            chk("load_state", state, (i == LOAD_WORDS - 1) ? 4 : 2);
            chk("load_CEN", CEN, (i == LOAD_WORDS - 1) ? 1'b0 : 1'b1);
        end
        load_valid = 1'b0;
    endtask

    // mode 0: quiet inputs; mode 1: random stall/start/load_valid; mode 2: 3-cycle stall pulses at rd 7
    task automatic run_seq(input int mode, input int abort_at);
        int   kind;
        int   n;
        int   cyc;
        int   reads;
        int   tvs;
        int   done_cyc;
        int   stall_left;
        logic prev_read;
        logic s;
        logic eff;
        kind = K_READ; n = 0; cyc = 0; reads = 0; tvs = 0; done_cyc = -1;
        stall_left = 0; prev_read = 1'b0;
        while (1) begin
            chk("run_CEN", CEN, (kind != K_READ));
            chk("run_tw_valid", tw_valid, prev_read);
            chk("run_done", done, (kind == K_DONE));
            chk("run_busy", busy, (kind != K_IDLE));
            chk("run_ROM0_w", ROM0_w, (cyc == 0));
            chk("run_load_err", load_err, 1'b0);
            chk("run_load_ready", load_ready, 1'b0);
            case (kind)
                K_READ, K_STALL: begin
                    chk("run_state", state, ((n / BLOCK_LEN) % 2 == 1) ? 6 : 4);
                    chk("run_stage", stage_counter, n / RPS);
                end
                K_GAP:  chk("gap_state", state, 5);
                K_DONE: begin
                    chk("done_state", state, 8);
                    chk("done_stage", stage_counter, STAGE_NUM - 1);
                end
                default: begin
                    chk("idle_state", state, 0);
                    chk("idle_stage", stage_counter, 0);
                end
            endcase
            if (!CEN) reads++;
            if (tw_valid) tvs++;
            if (done) done_cyc = cyc;
            if (kind == K_IDLE) break;
            if (cyc >= CYC_LIMIT) begin
                n_vec++; n_err++;
                $display("FAIL run_timeout: still running after %0d cycles, expected idle", cyc);
                break;
            end
            if (abort_at >= 0 && kind == K_READ && n == abort_at) begin
                rst = 1'b1; stall = 1'b0; start = 1'b0; load_valid = 1'b0;
                tick();
                rst = 1'b0;
                chk_reset("midrun_rst");
                return;
            end
            s = 1'b0;
            if (mode == 1) begin
                s          = ($urandom_range(0, 3) == 0);
                start      = ($urandom_range(0, 7) == 0);
                load_valid = $urandom_range(0, 1);
                load_data  = {$urandom, $urandom};
            end else if (mode == 2) begin
                if (stall_left == 0 && kind == K_READ && (n % BLOCK_LEN) == 7 && ((n / BLOCK_LEN) % 5) == 0)
                    stall_left = 3;
                s = (stall_left > 0);
                if (stall_left > 0) stall_left--;
            end
            stall = s;
            eff = STALL_EN && s;
            prev_read = (kind == K_READ);
            case (kind)
                K_READ: begin
                    if ((n + 1) % RPS == 0) kind = (n + 1 == TOTAL) ? K_DONE : K_GAP;
                    else kind = eff ? K_STALL : K_READ;
                    n = n + 1;
                end
                K_STALL: kind = eff ? K_STALL : K_READ;
                K_GAP:   kind = K_READ;
                default: kind = K_IDLE;
            endcase
            tick();
            cyc++;
        end
        stall = 1'b0; start = 1'b0; load_valid = 1'b0;
        chk("run_reads", reads, TOTAL);
        chk("run_tw_valid_count", tvs, TOTAL);
        if (mode == 0) chk("run_done_cycle", done_cyc, TOTAL + STAGE_NUM - 1);
    endtask

    typedef struct {
        logic        start;
        logic        lv;
        logic [63:0] d;
        logic        e_w;
        logic [63:0] e_hdo;
        logic [3:0]  e_state;
        logic        e_lr;
        logic        e_err;
        logic        e_cen;
        logic        e_tv;
    } vec_t;

    vec_t tbl [12];

    initial begin
        tbl[0]  = '{1'b0, 1'b1, 64'hFF, 1'b0, 64'h0,  4'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 64'h0,  1'b0, 64'h0,  4'd2, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 64'hA1, 1'b1, 64'hA1, 4'd2, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 64'hA2, 1'b1, 64'hA2, 4'd2, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 64'h0,  1'b0, 64'h0,  4'd2, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 64'h0,  1'b0, 64'h0,  4'd2, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 64'h1,  1'b1, 64'h1,  4'd2, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 64'h2,  1'b1, 64'h2,  4'd2, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 64'h3,  1'b1, 64'h3,  4'd2, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 64'h4,  1'b1, 64'h4,  4'd4, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 64'h0,  1'b0, 64'h0,  4'd4, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 1'b1, 64'h55, 1'b0, 64'h0,  4'd4, 1'b0, 1'b0, 1'b0, 1'b1};

        rst = 1'b1; start = 1'b0; load_valid = 1'b0; load_data = '0; stall = 1'b0;
        tick();
        tick();
        chk_reset("reset");
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            start      = tbl[i].start;
            load_valid = tbl[i].lv;
            load_data  = tbl[i].d;
            tick();
            chk("tbl_ROM0_w", ROM0_w, tbl[i].e_w);
            if (tbl[i].e_w) chk("tbl_hdo", horizontal_data_out, tbl[i].e_hdo);
            chk("tbl_state", state, tbl[i].e_state);
            chk("tbl_load_ready", load_ready, tbl[i].e_lr);
            chk("tbl_load_err", load_err, tbl[i].e_err);
            chk("tbl_CEN", CEN, tbl[i].e_cen);
            chk("tbl_tw_valid", tw_valid, tbl[i].e_tv);
            chk("tbl_busy", busy, (tbl[i].e_state != 4'd0));
        end
        start = 1'b0; load_valid = 1'b0;

        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset("run_rst");

        do_start();
        load4(64'h100);
        run_seq(0, -1);

        do_start();
        load4(64'h200);
        run_seq(1, RPS + 476);

        do_start();
        load4(64'h300);
        run_seq(2, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
